// File: rtl/cordic_pipe_if.sv
// cordic_pipe_if: handshake and data bundle for the CORDIC pipeline.
//   master: upstream sample source / downstream result sink (drives in_*, out_ready)
//   slave : the pipeline itself (drives in_ready, out_*)
//   in_valid/in_ready/in_mode, x_in/y_in (signed Q2.(WIDTH-2)), z_in (binary angle)
//   out_valid/out_ready/mode_out, x_out/y_out (signed Q4.(WIDTH-2)), z_out (binary angle)
interface cordic_pipe_if #(
  parameter int WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_mode;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic        [WIDTH-1:0] z_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH+1:0] x_out;
  logic signed [WIDTH+1:0] y_out;
  logic        [WIDTH-1:0] z_out;
  logic                    mode_out;

  modport master (
    output in_valid, in_mode, x_in, y_in, z_in, out_ready,
    input  in_ready, out_valid, x_out, y_out, z_out, mode_out
  );

  modport slave (
    input  in_valid, in_mode, x_in, y_in, z_in, out_ready,
    output in_ready, out_valid, x_out, y_out, z_out, mode_out
  );
endinterface

// File: rtl/cordic_pipe.sv
// cordic_pipe: fully pipelined CORDIC, rotation or vectoring selected per sample.
//   clk : rising-edge clock
//   rst : synchronous active-high reset, clears the whole pipeline
//   bus : cordic_pipe_if.slave, valid/ready in and out plus data and mode
// One pre-rotation stage folds the sample into the right half-plane, then ITER
// micro-rotation stages. Outputs come straight from the last stage register.
// Gain K (~1.64676) is not compensated.
module cordic_pipe #(
  parameter int WIDTH = 16,
  parameter int ITER  = 14
) (
  input  logic          clk,
  input  logic          rst,
  cordic_pipe_if.slave  bus
);

  localparam int XW = WIDTH + 2;

  // round(2^32 * atan(2^-i) / (2*pi))
  localparam logic [31:0] ATAN32 [0:31] = '{
    32'h20000000, 32'h12E4051E, 32'h09FB385B, 32'h051111D4,
    32'h028B0D43, 32'h0145D7E1, 32'h00A2F61E, 32'h00517C55,
    32'h0028BE53, 32'h00145F2F, 32'h000A2F98, 32'h000517CC,
    32'h00028BE6, 32'h000145F3, 32'h0000A2FA, 32'h0000517D,
    32'h000028BE, 32'h0000145F, 32'h00000A30, 32'h00000518,
    32'h0000028C, 32'h00000146, 32'h000000A3, 32'h00000051,
    32'h00000029, 32'h00000014, 32'h0000000A, 32'h00000005,
    32'h00000003, 32'h00000001, 32'h00000001, 32'h00000000
  };

  // Table entry scaled to WIDTH bits with round-half-up.
  function automatic logic [WIDTH-1:0] atan_entry(input int idx);
    logic [32:0] t;
    t = {1'b0, ATAN32[idx[4:0]]};
    if (WIDTH < 32) t = t + (33'd1 << (31 - WIDTH));
    t = t >> (32 - WIDTH);
    return t[WIDTH-1:0];
  endfunction

  logic [ITER:0]           vld;
  logic [ITER:0]           mde;
  logic signed [XW-1:0]    xr [0:ITER];
  logic signed [XW-1:0]    yr [0:ITER];
  logic        [WIDTH-1:0] zr [0:ITER];

  logic                    adv;
  logic                    flip;
  logic signed [XW-1:0]    x_ext;
  logic signed [XW-1:0]    y_ext;
  logic [ITER-1:0]         dpos;
  logic signed [XW-1:0]    xsh [0:ITER-1];
  logic signed [XW-1:0]    ysh [0:ITER-1];

  assign adv          = bus.out_ready | ~bus.out_valid;
  assign bus.in_ready = adv;

  always_comb begin
    x_ext = {{2{bus.x_in[WIDTH-1]}}, bus.x_in};
    y_ext = {{2{bus.y_in[WIDTH-1]}}, bus.y_in};
    // rotation: angle outside [-pi/2, pi/2); vectoring: vector in left half-plane
    flip  = bus.in_mode ? bus.x_in[WIDTH-1]
                        : (bus.z_in[WIDTH-1] ^ bus.z_in[WIDTH-2]);
  end

  // dpos = 1 means d = +1
  always_comb begin
    dpos = '0;
    for (int i = 0; i < ITER; i++) begin
      dpos[i] = mde[i] ? yr[i][XW-1] : ~zr[i][WIDTH-1];
      xsh[i]  = xr[i] >>> i;
      ysh[i]  = yr[i] >>> i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      mde <= '0;
      for (int i = 0; i <= ITER; i++) begin
        xr[i] <= '0;
        yr[i] <= '0;
        zr[i] <= '0;
      end
    end else if (adv) begin
      vld   <= {vld[ITER-1:0], bus.in_valid};
      mde   <= {mde[ITER-1:0], bus.in_mode};
      xr[0] <= flip ? -x_ext : x_ext;
      yr[0] <= flip ? -y_ext : y_ext;
      zr[0] <= {bus.z_in[WIDTH-1] ^ flip, bus.z_in[WIDTH-2:0]};
      for (int i = 0; i < ITER; i++) begin
        xr[i+1] <= dpos[i] ? xr[i] - ysh[i] : xr[i] + ysh[i];
        yr[i+1] <= dpos[i] ? yr[i] + xsh[i] : yr[i] - xsh[i];
        zr[i+1] <= dpos[i] ? zr[i] - atan_entry(i) : zr[i] + atan_entry(i);
      end
    end
  end

  assign bus.out_valid = vld[ITER];
  assign bus.mode_out  = mde[ITER];
  assign bus.x_out     = xr[ITER];
  assign bus.y_out     = yr[ITER];
  assign bus.z_out     = zr[ITER];

endmodule

// File: tb/tb_cordic_pipe.sv
// tb_cordic_pipe: self-checking bench for cordic_pipe (WIDTH=16, ITER=14).
// Directed accuracy/latency cases, backpressure, mid-stream reset and a random
// mixed-mode sweep against an arithmetic CORDIC model with a real-valued table.
module tb_cordic_pipe;

  localparam int W = 16;
  localparam int N = 14;

  typedef struct {
    bit           m;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] z;
  } stim_t;

  typedef struct {
    longint x;
    longint y;
    longint z;
    bit     m;
  } res_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_pipe_if #(.WIDTH(W)) bus ();

  cordic_pipe #(.WIDTH(W), .ITER(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int     total = 0;
  int     bad   = 0;
  longint atan_tab [N];
  res_t   got_q [$];
  res_t   exp_q [$];
  bit     sweep_done;

  // Result sink: a transfer happens on the next rising edge.
  initial forever begin
    @(negedge clk);
    #2;
    if (!rst && bus.out_valid && bus.out_ready) begin
      res_t r;
      r.x = longint'(bus.x_out);
      r.y = longint'(bus.y_out);
      r.z = longint'(bus.z_out);
      r.m = bus.mode_out;
      got_q.push_back(r);
    end
  end

  function automatic void init_tab();
    real    a, v;
    longint t32;
    for (int i = 0; i < N; i++) begin
      a   = $atan(1.0 / (2.0 ** i));
      v   = a * 4294967296.0 / (2.0 * 3.14159265358979323846);
      t32 = longint'($floor(v + 0.5));
      atan_tab[i] = (t32 + 32768) >>> 16;
    end
  endfunction

  function automatic longint sangle(longint z);
    return (z >= 32768) ? z - 65536 : z;
  endfunction

  function automatic res_t model(stim_t s);
    res_t   r;
    longint x, y, z, xn, yn;
    longint d;
    bit     flip;
    x = longint'($signed(s.x));
    y = longint'($signed(s.y));
    z = longint'(s.z);
    if (s.m) flip = (x < 0);
    else     flip = (sangle(z) >= 16384) || (sangle(z) < -16384);
    if (flip) begin
      x = -x;
      y = -y;
      z = (z + 32768) % 65536;
    end
    for (int i = 0; i < N; i++) begin
      if (s.m) d = (y < 0) ? 1 : -1;
      else     d = (sangle(z) >= 0) ? 1 : -1;
      xn = x - d * (y >>> i);
      yn = y + d * (x >>> i);
      z  = (((z - d * atan_tab[i]) % 65536) + 65536) % 65536;
      x  = xn;
      y  = yn;
    end
    r.x = x;
    r.y = y;
    r.z = z;
    r.m = s.m;
    return r;
  endfunction

  function automatic longint labs(longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic longint zdist(longint a, longint b);
    return labs(sangle(((a - b) % 65536 + 65536) % 65536));
  endfunction

  function automatic stim_t rand_stim(bit m);
    stim_t s;
    s.m = m;
    s.x = W'($urandom);
    s.y = W'($urandom);
    s.z = W'($urandom);
    if ($urandom_range(0, 15) == 0) begin
      s.x = 16'h8000;
      s.y = 16'h8000;
    end
    return s;
  endfunction

  // Present one sample and hold it until accepted; in_valid stays high afterwards.
  task automatic send(input stim_t s);
    int guard;
    guard = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mode  = s.m;
    bus.x_in     = s.x;
    bus.y_in     = s.y;
    bus.z_in     = s.z;
    #1;
    while (!bus.in_ready && guard < 1000) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (guard >= 1000) begin
      total++;
      bad++;
      $display("FAIL send_timeout in_ready=%0b required=1", bus.in_ready);
    end
    exp_q.push_back(model(s));
  endtask

  task automatic idle();
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (got_q.size() < exp_q.size() && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    repeat (20) @(negedge clk);
  endtask

  // Single sample; returns the first visible result and its latency in cycles.
  task automatic run_one(input stim_t s, output res_t r, output int lat);
    got_q.delete();
    exp_q.delete();
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_mode  = s.m;
    bus.x_in     = s.x;
    bus.y_in     = s.y;
    bus.z_in     = s.z;
    exp_q.push_back(model(s));
    for (lat = 1; lat <= 40; lat++) begin
      @(negedge clk);
      if (lat == 1) bus.in_valid = 1'b0;
      #2;
      if (bus.out_valid) break;
    end
    r.x = longint'(bus.x_out);
    r.y = longint'(bus.y_out);
    r.z = longint'(bus.z_out);
    r.m = bus.mode_out;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_mode = 1'b0;
    bus.x_in = '0;
    bus.y_in = '0;
    bus.z_in = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b required=0", bus.out_valid); end
    total++; if (bus.x_out !== '0) begin bad++; $display("FAIL reset_x_out got=%0h required=0", bus.x_out); end
    total++; if (bus.y_out !== '0) begin bad++; $display("FAIL reset_y_out got=%0h required=0", bus.y_out); end
    total++; if (bus.z_out !== '0) begin bad++; $display("FAIL reset_z_out got=%0h required=0", bus.z_out); end
    total++; if (bus.mode_out !== 1'b0) begin bad++; $display("FAIL reset_mode_out got=%0b required=0", bus.mode_out); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b required=1", bus.in_ready); end
    // samples offered during reset are dropped
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.x_in = 16'h4000;
    repeat (2) @(negedge clk);
    bus.out_ready = 1'b1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    got_q.delete();
    repeat (20) @(negedge clk);
    total++; if (got_q.size() != 0) begin bad++; $display("FAIL reset_discard outputs=%0d required=0", got_q.size()); end
  endtask

  task automatic test_rotation();
    stim_t s; res_t r, e; int lat;
    s = '{1'b0, 16'h4000, 16'h0000, 16'h2000};
    run_one(s, r, lat);
    e = exp_q[0];
    total++; if (lat != 15) begin bad++; $display("FAIL rot_latency got=%0d required=15", lat); end
    total++; if (labs(r.x - 19079) > 6) begin bad++; $display("FAIL rot_x got=%0d required=19079+/-6", r.x); end
    total++; if (labs(r.y - 19079) > 6) begin bad++; $display("FAIL rot_y got=%0d required=19079+/-6", r.y); end
    total++; if (zdist(r.z, 0) > 2) begin bad++; $display("FAIL rot_z got=%0h required=0+/-2", r.z); end
    total++; if (r.x !== e.x || r.y !== e.y || r.z !== e.z) begin bad++; $display("FAIL rot_exact got=%0d,%0d,%0h required=%0d,%0d,%0h", r.x, r.y, r.z, e.x, e.y, e.z); end
  endtask

  task automatic test_vectoring();
    stim_t s; res_t r; int lat;
    s = '{1'b1, 16'h4000, 16'h4000, 16'h0000};
    run_one(s, r, lat);
    total++; if (lat != 15) begin bad++; $display("FAIL vec_latency got=%0d required=15", lat); end
    total++; if (labs(r.x - 38158) > 8) begin bad++; $display("FAIL vec_x got=%0d required=38158+/-8", r.x); end
    total++; if (labs(r.y) > 4) begin bad++; $display("FAIL vec_y got=%0d required=0+/-4", r.y); end
    total++; if (zdist(r.z, 16'h2000) > 2) begin bad++; $display("FAIL vec_z got=%0h required=2000+/-2", r.z); end
    total++; if (r.m !== 1'b1) begin bad++; $display("FAIL vec_mode got=%0b required=1", r.m); end
  endtask

  task automatic test_quadrant();
    stim_t s; res_t r; int lat;
    s = '{1'b0, 16'h4000, 16'h0000, 16'h8000};
    run_one(s, r, lat);
    total++; if (labs(r.x + 26981) > 6) begin bad++; $display("FAIL quad_rot_x got=%0d required=-26981+/-6", r.x); end
    total++; if (labs(r.y) > 6) begin bad++; $display("FAIL quad_rot_y got=%0d required=0+/-6", r.y); end
    total++; if (r.m !== 1'b0) begin bad++; $display("FAIL quad_rot_mode got=%0b required=0", r.m); end
    s = '{1'b1, 16'hC000, 16'h0000, 16'h0000};
    run_one(s, r, lat);
    total++; if (zdist(r.z, 16'h8000) > 2) begin bad++; $display("FAIL quad_vec_z got=%0h required=8000+/-2", r.z); end
    total++; if (r.x !== exp_q[0].x || r.y !== exp_q[0].y) begin bad++; $display("FAIL quad_vec_exact got=%0d,%0d required=%0d,%0d", r.x, r.y, exp_q[0].x, exp_q[0].y); end
  endtask

  task automatic test_back_to_back();
    int run_len, guard;
    got_q.delete();
    exp_q.delete();
    run_len = 0;
    fork
      begin
        for (int k = 0; k < 20; k++) send(rand_stim(k[0]));
        idle();
      end
      begin
        guard = 0;
        while (!bus.out_valid && guard < 100) begin @(negedge clk); #2; guard++; end
        while (bus.out_valid && run_len < 100) begin run_len++; @(negedge clk); #2; end
      end
    join
    drain();
    total++; if (run_len != 20) begin bad++; $display("FAIL b2b_run_length got=%0d required=20", run_len); end
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      total++;
      if (got_q[k] != exp_q[k]) begin bad++; $display("FAIL b2b_sample[%0d] got=%0d,%0d,%0h,%0b required=%0d,%0d,%0h,%0b", k, got_q[k].x, got_q[k].y, got_q[k].z, got_q[k].m, exp_q[k].x, exp_q[k].y, exp_q[k].z, exp_q[k].m); end
    end
  endtask

  task automatic test_backpressure();
    int guard; logic [W+1:0] sx, sy; logic [W-1:0] sz; logic sm;
    got_q.delete();
    exp_q.delete();
    fork
      begin
        for (int k = 0; k < 20; k++) send(rand_stim(k[1]));
        idle();
      end
      begin
        guard = 0;
        while (!bus.out_valid && guard < 100) begin @(negedge clk); #2; guard++; end
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        sx = bus.x_out; sy = bus.y_out; sz = bus.z_out; sm = bus.mode_out;
        for (int j = 0; j < 5; j++) begin
          if (j > 0) begin
            @(negedge clk);
            #1;
            total++;
            if (bus.out_valid !== 1'b1 || bus.x_out !== sx || bus.y_out !== sy || bus.z_out !== sz || bus.mode_out !== sm) begin
              bad++; $display("FAIL bp_frozen[%0d] got=%0b,%0h,%0h,%0h required=1,%0h,%0h,%0h", j, bus.out_valid, bus.x_out, bus.y_out, bus.z_out, sx, sy, sz);
            end
          end
          total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready[%0d] got=%0b required=0", j, bus.in_ready); end
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        #1;
        total++;
        if (bus.out_valid !== 1'b1 || bus.x_out !== sx || bus.y_out !== sy || bus.z_out !== sz || bus.mode_out !== sm) begin
          bad++; $display("FAIL bp_frozen_last got=%0b,%0h,%0h,%0h required=1,%0h,%0h,%0h", bus.out_valid, bus.x_out, bus.y_out, bus.z_out, sx, sy, sz);
        end
      end
    join
    drain();
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL bp_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      total++;
      if (got_q[k] != exp_q[k]) begin bad++; $display("FAIL bp_sample[%0d] got=%0d,%0d,%0h required=%0d,%0d,%0h", k, got_q[k].x, got_q[k].y, got_q[k].z, exp_q[k].x, exp_q[k].y, exp_q[k].z); end
    end
  endtask

  task automatic test_reset_midstream();
    stim_t s; res_t r; int lat, stale;
    got_q.delete();
    exp_q.delete();
    for (int k = 0; k < 8; k++) send(rand_stim(k[0]));
    @(negedge clk);
    rst = 1'b1;
    bus.x_in = 16'h1234;
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%0b required=0", bus.out_valid); end
    total++;
    if (bus.x_out !== '0 || bus.y_out !== '0 || bus.z_out !== '0 || bus.mode_out !== 1'b0) begin
      bad++; $display("FAIL midrst_outputs got=%0h,%0h,%0h,%0b required=0,0,0,0", bus.x_out, bus.y_out, bus.z_out, bus.mode_out);
    end
    stale = 0;
    repeat (15) begin
      @(negedge clk);
      #1;
      if (bus.out_valid !== 1'b0) stale++;
    end
    total++; if (stale != 0) begin bad++; $display("FAIL midrst_stale cycles_valid=%0d required=0", stale); end
    s = rand_stim(1'b0);
    run_one(s, r, lat);
    total++; if (lat != 15) begin bad++; $display("FAIL postrst_latency got=%0d required=15", lat); end
    total++; if (r != exp_q[0]) begin bad++; $display("FAIL postrst_sample got=%0d,%0d,%0h required=%0d,%0d,%0h", r.x, r.y, r.z, exp_q[0].x, exp_q[0].y, exp_q[0].z); end
  endtask

  task automatic test_random_sweep();
    stim_t s;
    got_q.delete();
    exp_q.delete();
    sweep_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 10000; k++) begin
          s = rand_stim((k < 5000) ? k[0] : 1'($urandom_range(0, 1)));
          if ($urandom_range(0, 5) == 0) idle();
          send(s);
        end
        idle();
        sweep_done = 1'b1;
      end
      begin
        while (!sweep_done) begin
          @(negedge clk);
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    @(negedge clk);
    bus.out_ready = 1'b1;
    drain();
    total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL sweep_count got=%0d required=%0d", got_q.size(), exp_q.size()); end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      total++;
      if (got_q[k] != exp_q[k]) begin bad++; $display("FAIL sweep_sample[%0d] got=%0d,%0d,%0h,%0b required=%0d,%0d,%0h,%0b", k, got_q[k].x, got_q[k].y, got_q[k].z, got_q[k].m, exp_q[k].x, exp_q[k].y, exp_q[k].z, exp_q[k].m); end
    end
  endtask

  initial begin
    init_tab();
    test_reset();
    test_rotation();
    test_vectoring();
    test_quadrant();
    test_back_to_back();
    test_backpressure();
    test_reset_midstream();
    test_random_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cordic_pipe.md
CORDIC_PIPE -- requirements
Module: cordic_pipe

Interface
REQ-001 Parameter: WIDTH, default 16, data/angle width; legal range 8..32.
REQ-002 Parameter: ITER, default 14, number of micro-rotation stages; legal range 4..WIDTH.
REQ-003 Port: clk  in  1  rising-edge clock.
REQ-004 Port: rst  in  1  reset, synchronous, active-high.
REQ-005 Port: in_valid  in  1  input sample present.
REQ-006 Port: in_ready  out  1  block accepts a sample this cycle.
REQ-007 Port: in_mode  in  1  operating mode; 0 = rotation, 1 = vectoring.
REQ-008 Port: x_in, y_in  in  WIDTH each  signed Q2.(WIDTH-2).
REQ-009 Port: z_in  in  WIDTH  signed binary angle; 2^WIDTH LSB = 2*pi.
REQ-010 Port: out_valid  out  1  result present.
REQ-011 Port: out_ready  in  1  downstream accepts the result.
REQ-012 Port: x_out, y_out  out  WIDTH+2 each  signed Q4.(WIDTH-2).
REQ-013 Port: z_out  out  WIDTH  binary angle, same format as z_in.
REQ-014 Port: mode_out  out  1  in_mode carried with the sample.

Function
REQ-015 The pipeline SHALL advance when adv = out_ready OR NOT out_valid; in_ready SHALL equal adv combinationally.
REQ-016 When adv = 0, every stage register, including valid, mode and outputs, SHALL hold its value.
REQ-017 A sample is accepted when in_valid AND in_ready; if in_valid = 0 while adv = 1, a bubble (valid 0) SHALL enter.
REQ-018 Latency SHALL be exactly ITER+1 advancing cycles: 1 pre-rotation stage, ITER iteration stages, outputs driven directly from the last stage.
REQ-019 Throughput SHALL be one sample per cycle while out_ready = 1.
REQ-020 Internal x/y SHALL be WIDTH+2 bits, sign-extended from the inputs; z SHALL be WIDTH bits with modular wrap.
REQ-021 Pre-rotation in rotation mode: if z_in[W-1] XOR z_in[W-2] = 1 (|angle| > pi/2), x and y SHALL be negated and z_in[W-1] inverted (z += pi). Otherwise the sample SHALL pass unchanged.
REQ-022 Pre-rotation in vectoring mode: if x_in < 0, x and y SHALL be negated and z_in[W-1] inverted. Otherwise the sample SHALL pass unchanged.
REQ-023 Stage i (0..ITER-1) direction d: rotation d = +1 if z >= 0, else -1; vectoring d = +1 if y < 0, else -1.
REQ-024 Stage i SHALL compute: x' = x - d*(y>>>i); y' = y + d*(x>>>i); z' = z - d*atan_i. Shifts are arithmetic and truncating.
REQ-025 atan_i SHALL equal round(2^32*atan(2^-i)/(2*pi)) reduced to WIDTH bits by round-half-up right shift of 32-WIDTH. It is an elaboration-time constant table.
REQ-026 First 32-bit table values: 20000000, 12E4051E, 09FB385B, 051111D4, 028B0D43, 0145D7E1, 00A2F61E, 00517C55 (hex).
REQ-027 Gain is not compensated; |(x_out,y_out)| = K*|(x,y)|, with K ~ 1.64676.
REQ-028 Wrap: z arithmetic SHALL wrap modulo 2^WIDTH without saturation. x_in = y_in = most-negative SHALL NOT overflow the WIDTH+2 path.
REQ-029 Mode SHALL be per-sample; mixed modes in flight SHALL not interact.

Reset
REQ-030 On rst = 1 at a clock edge, all stage valid bits and out_valid SHALL clear to 0 on that edge. This applies mid-stream; in-flight samples are discarded.
REQ-031 On that edge, x_out, y_out, z_out and mode_out SHALL reset to 0.
REQ-032 During rst = 1, in_ready SHALL still follow REQ-015. Samples presented while rst = 1 SHALL be discarded.
REQ-033 The first sample accepted after rst deasserts SHALL appear ITER+1 cycles later.

Verification (WIDTH=16, ITER=14, out_ready=1 unless stated)
REQ-034 Rotation: x_in=4000h, y_in=0, z_in=2000h (pi/4), accepted at cycle c -> out_valid at c+15; x_out, y_out = 19079 +/-6; z_out = 0 +/-2.
REQ-035 Vectoring: x_in=4000h, y_in=4000h, z_in=0 -> x_out = 38158 +/-8; y_out = 0 +/-4; z_out = 2000h +/-2; mode_out = 1.
REQ-036 Quadrant: rotation, x_in=4000h, y_in=0, z_in=8000h (-pi) -> x_out = -26981 +/-6; y_out = 0 +/-6. Also vectoring, x_in=C000h, y_in=0 -> z_out = 8000h +/-2.
REQ-037 Backpressure: stream 20 back-to-back samples, drop out_ready for 5 cycles once out_valid = 1 -> in_ready = 0 and all outputs frozen for those 5 cycles. No sample lost or duplicated; order preserved.
REQ-038 Reset mid-stream: rst high for 1 cycle with 8 samples in flight -> out_valid = 0 and outputs 0 the next cycle. No stale sample emerges in the following 15 cycles unless new samples are applied.
REQ-039 Alternating modes, a random 10^4-sample sweep vs a bit-accurate reference model -> exact match.
